// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// Imported by the loader top and its byte assembler.
package prog_loader_pkg;

  localparam int addr_p           = 12;
  localparam int loader_timeout_p = 1024;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LEN   = 3'd1,
    LD_DATA  = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } t_loader_state;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_stream(input t_loader_state s);
    return (s == LD_LEN) || (s == LD_DATA);
  endfunction

  function automatic logic is_idle_like(input t_loader_state s);
    return (s == LD_IDLE) || (s == LD_DONE) || (s == LD_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_byte_asm.sv
// Packs four accepted stream bytes into a little-endian word.
// word_valid_o pulses combinationally with the fourth byte.
module prog_loader_byte_asm (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_en_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  // The last byte is the MSB; the first three sit in shift_q.
  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed program into memory,
// holding the core in reset until the image is complete.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W         = addr_p,
  parameter int TIMEOUT_CYCLES = loader_timeout_p
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [31:0]       mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_rstn_o,
  output logic [ADDR_W:0]   words_written_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0] MEM_WORDS = 33'd1 << ADDR_W;

  t_loader_state   state_q;
  t_loader_state   state_d;
  logic [31:0]     len_q;
  logic [TO_W-1:0] idle_q;
  logic            accept;
  logic            restart;
  logic            timed_out;
  logic [31:0]     word;
  logic            word_valid;
  logic [32:0]     wr_count;

  assign accept    = byte_valid_i & byte_ready_o;
  assign restart   = start_i & is_idle_like(state_q);
  assign timed_out = !accept && (idle_q == TO_LAST);
  assign wr_count  = 33'(words_written_o) + 33'd1;

  prog_loader_byte_asm u_asm (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (restart),
    .byte_en_i    (accept),
    .byte_i       (byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start_i) state_d = LD_LEN;
      end
      LD_LEN: begin
        if (word_valid) begin
          unique case (1'b1)
            (word == 32'd0):
              state_d = LD_DONE;
            ({1'b0, word} > MEM_WORDS):
              state_d = LD_ERR;
            default:
              state_d = LD_DATA;
          endcase
        end else if (timed_out) begin
          state_d = LD_ERR;
        end
      end
      LD_DATA: begin
        if (word_valid)     state_d = LD_WRITE;
        else if (timed_out) state_d = LD_ERR;
      end
      LD_WRITE: begin
        if (wr_count == {1'b0, len_q}) state_d = LD_DONE;
        else                           state_d = LD_DATA;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Status outputs are registered images of the next state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= LD_IDLE;
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      core_rstn_o  <= 1'b0;
      mem_wr_en_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_o <= is_stream(state_d);
      busy_o       <= is_stream(state_d) ||
                      (state_d == LD_WRITE);
      done_o       <= state_d == LD_DONE;
      err_o        <= state_d == LD_ERR;
      core_rstn_o  <= state_d == LD_DONE;
      mem_wr_en_o  <= state_d == LD_WRITE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      len_q           <= '0;
      words_written_o <= '0;
    end else if (restart) begin
      len_q           <= '0;
      words_written_o <= '0;
    end else if (state_q == LD_LEN && word_valid) begin
      len_q <= word;
    end else if (state_q == LD_WRITE) begin
      words_written_o <= words_written_o + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (state_q == LD_DATA && word_valid) begin
      mem_addr_o <= words_written_o[ADDR_W-1:0];
      mem_data_o <= word;
    end
  end

  // Idle-cycle counter; restarts on every byte and state change.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idle_q <= '0;
    end else if (accept || (state_d != state_q)) begin
      idle_q <= '0;
    end else if (is_stream(state_q)) begin
      idle_q <= idle_q + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized bench for prog_loader (ADDR_W=4,
// TIMEOUT_CYCLES=16) against a length/word-list reference model.
module tb_prog_loader;

  localparam int AW = 4;
  localparam int NW = 1 << AW;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          bvalid = 1'b0;
  logic [7:0]    bdata = 8'h00;
  logic          bready;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          core_rstn;
  logic [AW:0]   ww;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic [31:0]   mem[NW];

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .start_i         (start),
    .byte_i          (bdata),
    .byte_valid_i    (bvalid),
    .byte_ready_o    (bready),
    .mem_addr_o      (addr),
    .mem_wr_en_o     (wr_en),
    .mem_data_o      (wdata),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .core_rstn_o     (core_rstn),
    .words_written_o (ww)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Memory side: record every write strobe.
  always @(negedge clk) begin
    if (rstn) begin
      chk("done_err_excl", {63'd0, done & err}, 64'd0);
      chk("wr_outside_busy", {63'd0, wr_en & ~busy}, 64'd0);
      if (wr_en === 1'b1) begin
        log_addr.push_back(addr);
        log_data.push_back(wdata);
        mem[addr] = wdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           output bit acc);
    int n;
    bvalid = 1'b0;
    repeat (gap) @(negedge clk);
    bdata  = b;
    bvalid = 1'b1;
    n = 0;
    while (!bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = bready;
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gmin,
                           input int gmax,
                           output bit ok);
    bit a;
    int g;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = int'($urandom_range(gmax, gmin));
      send_byte(w[8*i +: 8], g, a);
      ok &= a;
    end
  endtask

  task automatic wait_end(output bit hit);
    int n;
    n = 0;
    while (!(done || err) && n < 400) begin
      @(negedge clk);
      n++;
    end
    hit = done || err;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: a legal length yields writes 0..len-1 of the words
  // sent, then DONE; an oversized length yields ERR, no writes.
  task automatic run_load(input string tag,
                          input logic [31:0] len,
                          input int gmin,
                          input int gmax,
                          input int poke);
    logic [31:0] words[$];
    int  nexp;
    bit  legal;
    bit  all_ok;
    bit  a;
    bit  hit;
    legal = (len <= 32'(NW));
    nexp  = legal ? int'(len) : 0;
    for (int i = 0; i < nexp; i++) words.push_back($urandom);
    log_addr.delete();
    log_data.delete();
    pulse_start();
    chk({tag, "/start_core_rstn"}, {63'd0, core_rstn}, 64'd0);
    chk({tag, "/start_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "/start_ww"}, 64'(ww), 64'd0);
    chk({tag, "/start_done"}, {63'd0, done}, 64'd0);
    all_ok = 1'b1;
    send_word(len, gmin, gmax, a);
    all_ok &= a;
    for (int i = 0; i < nexp; i++) begin
      if (i == poke) pulse_start();
      send_word(words[i], gmin, gmax, a);
      all_ok &= a;
    end
    wait_end(hit);
    chk({tag, "/finished"}, {63'd0, hit}, 64'd1);
    chk({tag, "/bytes_taken"}, {63'd0, all_ok}, 64'd1);
    chk({tag, "/done"}, {63'd0, done}, {63'd0, legal});
    chk({tag, "/err"}, {63'd0, err}, {63'd0, !legal});
    chk({tag, "/core_rstn"}, {63'd0, core_rstn}, {63'd0, legal});
    chk({tag, "/ww"}, 64'(ww), 64'(nexp));
    chk({tag, "/busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "/n_writes"}, 64'(log_addr.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
      chk({tag, "/addr"}, 64'(log_addr[i]), 64'(i));
      chk({tag, "/data"}, 64'(log_data[i]), 64'(words[i]));
      chk({tag, "/mem"}, 64'(mem[i]), 64'(words[i]));
    end
  endtask

  initial begin
    logic [7:0] seq[12];
    bit a;
    bit hit;
    logic [31:0] rlen;

    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, bready}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_core_rstn", {63'd0, core_rstn}, 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(wdata), 64'd0);
    chk("rst_ww", 64'(ww), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ready", {63'd0, bready}, 64'd0);

    // Directed two-word image.
    seq = '{8'h02, 8'h00, 8'h00, 8'h00,
            8'h13, 8'h00, 8'h00, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    log_addr.delete();
    log_data.delete();
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(seq[i], 0, a);
    chk("two_last_wr_en", {63'd0, wr_en}, 64'd1);
    chk("two_last_addr", 64'(addr), 64'd1);
    chk("two_last_data", 64'(wdata), 64'hDEADBEEF);
    chk("two_core_held", {63'd0, core_rstn}, 64'd0);
    @(negedge clk);
    chk("two_done", {63'd0, done}, 64'd1);
    chk("two_core_rstn", {63'd0, core_rstn}, 64'd1);
    chk("two_ww", 64'(ww), 64'd2);
    chk("two_n_writes", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("two_addr0", 64'(log_addr[0]), 64'd0);
      chk("two_data0", 64'(log_data[0]), 64'h13);
      chk("two_addr1", 64'(log_addr[1]), 64'd1);
      chk("two_data1", 64'(log_data[1]), 64'hDEADBEEF);
    end

    run_load("zero", 32'd0, 0, 0, -1);
    run_load("over17", 32'd17, 0, 0, -1);
    run_load("over_hi", 32'h0001_0005, 0, 1, -1);
    run_load("full16", 32'd16, 0, 0, -1);
    run_load("gap15", 32'd2, 15, 15, -1);
    run_load("poke_data", 32'd3, 0, 3, 0);

    // 16 idle cycles after the 2nd data byte must abort the load.
    log_addr.delete();
    log_data.delete();
    pulse_start();
    send_word(32'd2, 0, 0, a);
    send_byte(8'h13, 0, a);
    send_byte(8'h00, 0, a);
    send_byte(8'h00, TO, a);
    chk("to_byte_refused", {63'd0, a}, 64'd0);
    chk("to_err", {63'd0, err}, 64'd1);
    chk("to_done", {63'd0, done}, 64'd0);
    chk("to_core_rstn", {63'd0, core_rstn}, 64'd0);
    chk("to_n_writes", 64'(log_addr.size()), 64'd0);

    for (int k = 0; k < 6; k++) begin
      rlen = 32'($urandom_range(NW + 2, 0));
      run_load("rand", rlen, 0, 6, -1);
    end

    // Asynchronous reset in the middle of a data word.
    log_addr.delete();
    log_data.delete();
    pulse_start();
    send_word(32'd4, 0, 0, a);
    send_byte(8'hAA, 0, a);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", {63'd0, bready}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_err", {63'd0, err}, 64'd0);
    chk("arst_core_rstn", {63'd0, core_rstn}, 64'd0);
    chk("arst_addr", 64'(addr), 64'd0);
    chk("arst_data", 64'(wdata), 64'd0);
    chk("arst_ww", 64'(ww), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_idle_ready", {63'd0, bready}, 64'd0);
    chk("arst_idle_busy", {63'd0, busy}, 64'd0);
    chk("arst_no_write", 64'(log_addr.size()), 64'd0);

    run_load("after_rst", 32'd2, 0, 2, -1);
    wait_end(hit);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program writer for the core's word-addressed instruction/data memory.
- Receives a byte stream over a valid/ready handshake: a 4-byte little-endian word count, then the program words, each little-endian.
- Writes each assembled word into memory through the memory's write port.
- Holds the core in reset until the load completes, then releases it.

Parameters:
- ADDR_W, addr_p (from riscv_pkg): memory word-address width.
- TIMEOUT_CYCLES, 1024: max consecutive cycles in LEN/DATA with no accepted byte before ERR.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  load request pulse; honoured only in IDLE, DONE, ERR
- byte_i  in  8  stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader can accept a byte
- mem_addr_o  out  ADDR_W  word address of write
- mem_wr_en_o  out  1  single-cycle memory write strobe
- mem_data_o  out  32  write data
- busy_o  out  1  state is LEN, DATA or WRITE
- done_o  out  1  load completed successfully
- err_o  out  1  load aborted
- core_rstn_o  out  1  active-low reset to the core; 1 only in DONE
- words_written_o  out  ADDR_W+1  words written in current load

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous and active-low on rstn_i. On reset assertion, immediately:
  - state=IDLE
  - byte_ready_o, mem_wr_en_o, busy_o, done_o, err_o = 0
  - core_rstn_o = 0
  - mem_addr_o, mem_data_o, words_written_o = 0
  - internal len, byte count and timeout counter = 0
- Reset mid-load does not undo partial writes.
- Handshake: a byte is accepted when byte_valid_i & byte_ready_o in the same cycle. byte_ready_o is a registered function of state: 1 only in LEN and DATA.
- States:
  - IDLE: on start_i go to LEN. Clear len, the 2-bit byte counter, words_written_o and the timeout counter.
  - LEN: accepted bytes fill len[7:0], [15:8], [23:16], [31:24] in order. After the 4th byte:
    - len==0 -> DONE
    - len > 2**ADDR_W (32-bit unsigned compare) -> ERR
    - otherwise -> DATA
  - DATA: accepted bytes fill word bits [7:0]..[31:24] in order. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - mem_wr_en_o=1, mem_addr_o=words_written_o[ADDR_W-1:0], mem_data_o=assembled word.
    - words_written_o increments.
    - If the incremented count == len -> DONE, else -> DATA.
  - DONE: done_o=1, core_rstn_o=1. start_i -> LEN with the same clearing as IDLE; core_rstn_o=0 from the next cycle.
  - ERR: err_o=1, core_rstn_o=0. start_i -> LEN with the same clearing as IDLE.
- Timing:
  - Memory write occurs in the cycle after the 4th data byte is accepted.
  - Peak throughput is 1 word per 5 cycles.
  - done_o asserts the cycle after the last WRITE.
- Timeout:
  - The counter runs in LEN/DATA and clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES goes to ERR.
  - A byte accepted in the same cycle the count is reached wins: no ERR.
- start_i in LEN/DATA/WRITE is ignored.
- done_o and err_o are never both 1. Both clear on the cycle the FSM leaves DONE/ERR.
- mem_wr_en_o is never asserted outside WRITE. mem_addr_o and mem_data_o hold their last values otherwise.
- Full-memory load: len == 2**ADDR_W is legal. The last write goes to address 2**ADDR_W-1 and words_written_o reaches 2**ADDR_W with no wrap.

Decomposition:
- riscv_pkg additions:
  - t_loader_state enum (IDLE, LEN, DATA, WRITE, DONE, ERR)
  - loader_timeout_p default constant
- Optional sub-module byte_assembler: shifts 4 accepted bytes into a little-endian 32-bit word and pulses word_valid. It is used for both the length and data phases.

Test Plan:
- Two-word load: start_i, then bytes 02 00 00 00 13 00 00 00 EF BE AD DE -> mem writes addr0=0x00000013 and addr1=0xDEADBEEF. After that, done_o=1, core_rstn_o=1, words_written_o=2.
- Zero length: start_i, then bytes 00 00 00 00 -> DONE, no mem_wr_en_o pulse, core_rstn_o=1.
- Overflow with ADDR_W=4: len bytes 11 00 00 00 (17) -> err_o=1, no writes, core_rstn_o=0. Len 10 00 00 00 (16) with 16 words -> last write at addr 15, words_written_o=16.
- Gaps and timeout with TIMEOUT_CYCLES=16: byte_valid_i gaps of 15 cycles -> load completes correctly. A 16-cycle gap after the 2nd data byte -> err_o=1, no write for that word.
- start_i pulsed during DATA -> ignored, load completes. start_i in DONE -> core_rstn_o=0 next cycle and a fresh load overwrites from addr 0.
- rstn_i asserted mid-DATA -> all outputs at reset values without waiting for a clock edge. After release, state is IDLE and byte_ready_o=0.
